// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module : mul_pkg
// Brief  : Shared types and elaboration helpers for the iterative multiply-add.
// Rev    : 1.0  initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    function automatic int mul_iters(input int dw, input int bpc);
        return (bpc > 0) ? (dw / bpc) : 1;
    endfunction

    function automatic bit mul_cfg_ok(input int dw, input int bpc);
        return (bpc > 0) && (bpc <= dw) && ((dw % bpc) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_pp_gen.sv
`default_nettype none
// ============================================================================
// Module : mul_pp_gen
// Brief  : Combinational partial product of a narrow multiplier digit and a
//          double-width multiplicand.
// Rev    : 1.0  initial release
// ============================================================================
module mul_pp_gen #(
    parameter int BPC       = 1,
    parameter int ACC_WIDTH = 64
) (
    input  logic [BPC-1:0]       i_digit,
    input  logic [ACC_WIDTH-1:0] i_mcand,
    output logic [ACC_WIDTH-1:0] o_pp
);

    assign o_pp = i_mcand * ACC_WIDTH'(i_digit);

endmodule
`default_nettype wire

// File: rtl/mul_add_iter.sv
`default_nettype none
// ============================================================================
// Module : mul_add_iter
// Brief  : Iterative unsigned a*b+c, BITS_PER_CYCLE multiplier bits per clock,
//          fixed latency, valid/ready on both sides.
// Rev    : 1.0  initial release
// ============================================================================
module mul_add_iter
    import mul_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mul_ready_in,
    input  logic                  mul_valid_in,
    input  logic [DATA_WIDTH-1:0] mul_a_in,
    input  logic [DATA_WIDTH-1:0] mul_b_in,
    input  logic [DATA_WIDTH-1:0] mul_c_in,
    input  logic                  mul_ready_out,
    output logic                  mul_valid_out,
    output logic [DATA_WIDTH-1:0] mul_product_out,
    output logic                  mul_overflow_out
);

    localparam int c_ITER  = mul_iters(DATA_WIDTH, BITS_PER_CYCLE);
    localparam int c_CNT_W = (c_ITER > 1) ? $clog2(c_ITER) : 1;
    localparam int c_ACC_W = 2 * DATA_WIDTH;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_ITER - 1);

    if (!mul_cfg_ok(DATA_WIDTH, BITS_PER_CYCLE)) begin : g_cfg_check
        $error("mul_add_iter: BITS_PER_CYCLE must divide DATA_WIDTH");
    end

    mul_state_t           r_state;
    mul_state_t           w_state_nxt;
    logic                 w_ready_in;
    logic                 w_load;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_ACC_W-1:0]   r_acc;
    logic [DATA_WIDTH-1:0] r_a_sh;
    logic [c_ACC_W-1:0]   r_b_sh;
    logic [c_ACC_W-1:0]   w_pp;

    mul_pp_gen #(
        .BPC       (BITS_PER_CYCLE),
        .ACC_WIDTH (c_ACC_W)
    ) u_pp_gen (
        .i_digit (r_a_sh[BITS_PER_CYCLE-1:0]),
        .i_mcand (r_b_sh),
        .o_pp    (w_pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready_in  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready_in = 1'b1;
                if (mul_valid_in) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // A result leaving and a new set arriving share the same edge.
                w_ready_in = mul_ready_out;
                if (mul_ready_out) begin
                    w_state_nxt = mul_valid_in ? BUSY : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign mul_ready_in = w_ready_in & ~rst;
    assign w_load       = mul_valid_in & mul_ready_in;

    // Datapath is deliberately unreset; it is only observed in DONE.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_acc  <= {{DATA_WIDTH{1'b0}}, mul_c_in};
            r_a_sh <= mul_a_in;
            r_b_sh <= {{DATA_WIDTH{1'b0}}, mul_b_in};
            r_cnt  <= '0;
        end else if (r_state == BUSY) begin
            r_acc  <= r_acc + w_pp;
            r_a_sh <= r_a_sh >> BITS_PER_CYCLE;
            r_b_sh <= r_b_sh << BITS_PER_CYCLE;
            r_cnt  <= r_cnt + c_CNT_W'(1);
        end
    end

    assign mul_valid_out    = (r_state == DONE) & ~rst;
    assign mul_product_out  = r_acc[DATA_WIDTH-1:0];
    assign mul_overflow_out = |r_acc[c_ACC_W-1:DATA_WIDTH];

endmodule
`default_nettype wire
